// File: rtl/ram_bus_pkg.sv
// Shared definitions for the CPU RAM bus: read FSM states, lane count, wrap math.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package ram_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DRIVE
  } rd_state_t;

  localparam int BYTE_LANES = 8;

  // Byte index of lane k of an access at addr, wrapped into a power-of-two memory.
  function automatic logic [63:0] lane_index(input logic [63:0] addr,
                                             input logic [63:0] k,
                                             input logic [63:0] depth);
    return (addr + k) & (depth - 64'd1);
  endfunction

endpackage

// File: rtl/ram_responder_if.sv
// CPU-side RAM bus strobes plus the byte preload port (tri-state data stays a plain port).
// Latency: n/a (wiring only).
// Backpressure: ld_busy tells the loader its byte was dropped this cycle.
interface ram_responder_if;
  logic [63:0] bus_addr;
  logic        ram_cs;
  logic        ram_we;
  logic        ram_oe;
  logic        ram_ack;
  logic        ld_en;
  logic [63:0] ld_addr;
  logic [7:0]  ld_data;
  logic        ld_busy;

  modport master (
    output bus_addr, ram_cs, ram_we, ram_oe, ld_en, ld_addr, ld_data,
    input  ram_ack, ld_busy
  );

  modport slave (
    input  bus_addr, ram_cs, ram_we, ram_oe, ld_en, ld_addr, ld_data,
    output ram_ack, ld_busy
  );
endinterface

// File: rtl/ram_byte_array.sv
// Byte storage with one 8-byte read port, one 8-byte write port and one byte write port.
// Latency: combinational read; writes land at the clock edge.
// Backpressure: none; the caller keeps the two write ports mutually exclusive.
module ram_byte_array
  import ram_bus_pkg::*;
#(
  parameter int DEPTH_BYTES = 4096
) (
  input  logic        clk,
  input  logic [63:0] rd_addr,
  output logic [63:0] rd_dat,
  input  logic        wr_en,
  input  logic [63:0] wr_addr,
  input  logic [63:0] wr_dat,
  input  logic        bw_en,
  input  logic [63:0] bw_addr,
  input  logic [7:0]  bw_dat
);
  localparam int AW = $clog2(DEPTH_BYTES);

  logic [7:0]    mem [DEPTH_BYTES];
  logic [AW-1:0] widx [BYTE_LANES];
  logic [AW-1:0] bidx;
  logic          unused_bw_hi;

  assign bidx         = bw_addr[AW-1:0];
  assign unused_bw_hi = ^bw_addr[63:AW];

  // Lane k (big-endian: lane 0 is bits 63:56) maps to byte addr+k, wrapped.
  for (genvar k = 0; k < BYTE_LANES; k++) begin : g_lane
    logic [63:0]   w_full;
    logic [63:0]   r_full;
    logic [AW-1:0] ridx;
    logic          unused_lane_hi;

    assign w_full         = lane_index(wr_addr, 64'(k), 64'(DEPTH_BYTES));
    assign r_full         = lane_index(rd_addr, 64'(k), 64'(DEPTH_BYTES));
    assign widx[k]        = w_full[AW-1:0];
    assign ridx           = r_full[AW-1:0];
    assign unused_lane_hi = ^{w_full[63:AW], r_full[63:AW]};
    assign rd_dat[8*(BYTE_LANES-1-k) +: 8] = mem[ridx];
  end

  // Commit the 8-byte bus write, otherwise the preload byte; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int k = 0; k < BYTE_LANES; k++) begin
        mem[widx[k]] <= wr_dat[8*(BYTE_LANES-1-k) +: 8];
      end
    end else if (bw_en) begin
      mem[bidx] <= bw_dat;
    end
  end

endmodule

// File: rtl/ram_responder.sv
// Shared-RAM bus responder: 8-byte reads after WAIT_STATES, 1-cycle 8-byte writes, byte preload.
// Latency: read data/ack from WAIT_STATES+1 edges after the request is sampled; writes at the edge.
// Backpressure: preload bytes are dropped while ram_cs is high (ld_busy); reads held until rd_req drops.
module ram_responder
  import ram_bus_pkg::*;
#(
  parameter int DEPTH_BYTES = 4096,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              reset,
  ram_responder_if.slave    cpu,
  inout  wire        [63:0] bus_data
);
  localparam logic [3:0] WS_RELOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  rd_state_t   state_q, state_n;
  logic [3:0]  wcnt_q, wcnt_n;
  logic [63:0] lat_addr_q, lat_addr_n;
  logic [63:0] rdata_q;
  logic [63:0] mem_rd_dat;
  logic        rd_req;
  logic        drive;

  assign rd_req      = cpu.ram_cs && cpu.ram_oe && !cpu.ram_we;
  assign drive       = (state_q == ST_DRIVE) && rd_req;
  assign cpu.ram_ack = drive;
  assign cpu.ld_busy = cpu.ram_cs;
  assign bus_data    = drive ? rdata_q : 'z;

  // The read port follows the next latched address so rdata is already correct on
  // entry to DRIVE, including the zero-wait-state and address-change-in-DRIVE cases.
  ram_byte_array #(
    .DEPTH_BYTES (DEPTH_BYTES)
  ) u_array (
    .clk     (clk),
    .rd_addr (lat_addr_n),
    .rd_dat  (mem_rd_dat),
    .wr_en   (cpu.ram_cs && cpu.ram_we),
    .wr_addr (cpu.bus_addr),
    .wr_dat  (bus_data),
    .bw_en   (cpu.ld_en && !cpu.ram_cs),
    .bw_addr (cpu.ld_addr),
    .bw_dat  (cpu.ld_data)
  );

  // Next-state logic: count wait states, restart on address change, abort when rd_req drops.
  always_comb begin
    state_n    = state_q;
    wcnt_n     = wcnt_q;
    lat_addr_n = lat_addr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (rd_req) begin
          lat_addr_n = cpu.bus_addr;
          if (WAIT_STATES == 0) begin
            state_n = ST_DRIVE;
          end else begin
            state_n = ST_WAIT;
            wcnt_n  = WS_RELOAD;
          end
        end
      end
      ST_WAIT: begin
        if (!rd_req) begin
          state_n = ST_IDLE;
        end else if (cpu.bus_addr != lat_addr_q) begin
          lat_addr_n = cpu.bus_addr;
          wcnt_n     = WS_RELOAD;
        end else if (wcnt_q == 4'd0) begin
          state_n = ST_DRIVE;
        end else begin
          wcnt_n = wcnt_q - 4'd1;
        end
      end
      ST_DRIVE: begin
        if (!rd_req) begin
          state_n = ST_IDLE;
        end else if (cpu.bus_addr != lat_addr_q) begin
          lat_addr_n = cpu.bus_addr;
          if (WAIT_STATES != 0) begin
            state_n = ST_WAIT;
            wcnt_n  = WS_RELOAD;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // FSM registers; reset abandons any read in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      wcnt_q     <= 4'd0;
      lat_addr_q <= 64'd0;
    end else begin
      state_q    <= state_n;
      wcnt_q     <= wcnt_n;
      lat_addr_q <= lat_addr_n;
    end
  end

  // Read data register tracks memory while a read is pending.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= 64'd0;
    end else if (state_n != ST_IDLE) begin
      rdata_q <= mem_rd_dat;
    end
  end

endmodule

// File: tb/tb_ram_responder.sv
// Self-checking bench for ram_responder: table of bus writes/reads plus hand-written corner cases.
// Latency: reads are expected WAIT_STATES+1 cycles after the request cycle.
// Backpressure: preload collision with ram_cs checked via ld_busy and memory contents.
module tb_ram_responder;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ram_responder_if a_if ();
  ram_responder_if b_if ();

  wire  [63:0] a_dat;
  wire  [63:0] b_dat;
  logic        a_drv;
  logic        b_drv;
  logic [63:0] a_wdat;
  logic [63:0] b_wdat;

  assign a_dat = a_drv ? a_wdat : 'z;
  assign b_dat = b_drv ? b_wdat : 'z;

  ram_responder #(.DEPTH_BYTES(4096), .WAIT_STATES(1)) u_dut (
    .clk      (clk),
    .reset    (reset),
    .cpu      (a_if.slave),
    .bus_data (a_dat)
  );

  ram_responder #(.DEPTH_BYTES(4096), .WAIT_STATES(3)) u_dut_ws3 (
    .clk      (clk),
    .reset    (reset),
    .cpu      (b_if.slave),
    .bus_data (b_dat)
  );

  typedef struct {
    logic        is_wr;
    logic [63:0] addr;
    logic [63:0] dat;   // write data, or expected read data
  } vec_t;

  vec_t        vecs [10];
  logic [63:0] exp_q [$];
  int          errors = 0;
  int          checks = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic a_idle();
    a_if.ram_cs = 1'b0;
    a_if.ram_we = 1'b0;
    a_if.ram_oe = 1'b0;
    a_if.ld_en  = 1'b0;
    a_drv       = 1'b0;
  endtask

  task automatic a_write(input logic [63:0] addr, input logic [63:0] dat);
    a_if.bus_addr = addr;
    a_wdat        = dat;
    a_drv         = 1'b1;
    a_if.ram_cs   = 1'b1;
    a_if.ram_we   = 1'b1;
    a_if.ram_oe   = 1'b1;   // must be ignored during a write
    #1 chk("wr_no_ack", 64'(a_if.ram_ack), 64'd0);
    tick();
    a_idle();
  endtask

  task automatic a_load(input logic [63:0] addr, input logic [7:0] dat);
    a_if.ld_addr = addr;
    a_if.ld_data = dat;
    a_if.ld_en   = 1'b1;
    #1 chk("ld_busy_idle", 64'(a_if.ld_busy), 64'd0);
    tick();
    a_if.ld_en = 1'b0;
  endtask

  // Waits for ram_ack with a cycle budget, checks latency and scoreboard data, then aborts.
  task automatic a_wait_ack(input string nm, input int exp_lat);
    int c;
    c = 0;
    #1;
    while (!a_if.ram_ack && c < 20) begin
      @(posedge clk);
      #2;
      c++;
    end
    chk({nm, "_lat"}, 64'(c), 64'(exp_lat));
    if (a_if.ram_ack) begin
      chk({nm, "_data"}, a_dat, exp_q.pop_front());
    end else begin
      void'(exp_q.pop_front());
    end
    a_if.ram_oe = 1'b0;
    #1 chk({nm, "_release"}, 64'(a_if.ram_ack), 64'd0);
    tick();
    a_idle();
  endtask

  task automatic a_read(input string nm, input logic [63:0] addr, input logic [63:0] exp);
    a_if.bus_addr = addr;
    a_if.ram_cs   = 1'b1;
    a_if.ram_oe   = 1'b1;
    a_if.ram_we   = 1'b0;
    exp_q.push_back(exp);
    a_wait_ack(nm, 2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;

    vecs[0] = '{1'b0, 64'h0,                   64'h0102030405060708};
    vecs[1] = '{1'b1, 64'h10,                  64'hDEADBEEFCAFEF00D};
    vecs[2] = '{1'b1, 64'h18,                  64'h0123456789ABCDEF};
    vecs[3] = '{1'b0, 64'h10,                  64'hDEADBEEFCAFEF00D};
    vecs[4] = '{1'b0, 64'h14,                  64'hCAFEF00D01234567};
    vecs[5] = '{1'b1, 64'hFFD,                 64'h1122334455667788};
    vecs[6] = '{1'b0, 64'hFFD,                 64'h1122334455667788};
    vecs[7] = '{1'b0, 64'h0000_0000_1000_0FFD, 64'h1122334455667788};
    vecs[8] = '{1'b0, 64'h0,                   64'h4455667788060708};
    vecs[9] = '{1'b0, 64'hFFE,                 64'h2233445566778806};

    reset         = 1'b1;
    a_idle();
    a_if.bus_addr = '0;
    a_if.ld_addr  = '0;
    a_if.ld_data  = '0;
    a_wdat        = '0;
    b_if.bus_addr = '0;
    b_if.ram_cs   = 1'b0;
    b_if.ram_we   = 1'b0;
    b_if.ram_oe   = 1'b0;
    b_if.ld_en    = 1'b0;
    b_if.ld_addr  = '0;
    b_if.ld_data  = '0;
    b_drv         = 1'b0;
    b_wdat        = '0;
    repeat (3) tick();
    chk("reset_ack", 64'(a_if.ram_ack), 64'd0);
    chk("reset_ld_busy", 64'(a_if.ld_busy), 64'd0);
    reset = 1'b0;
    tick();

    // Preload a program image while the CPU is quiet.
    for (int i = 0; i < 8; i++) a_load(64'(i), 8'(i + 1));

    // Table of bus writes and reads.
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].is_wr) a_write(vecs[i].addr, vecs[i].dat);
      else               a_read($sformatf("vec%0d", i), vecs[i].addr, vecs[i].dat);
    end

    // Preload collides with ram_cs: byte dropped, ld_busy raised.
    a_write(64'h20, 64'h5555555555555555);
    a_if.ram_cs  = 1'b1;
    a_if.ld_addr = 64'h20;
    a_if.ld_data = 8'hAA;
    a_if.ld_en   = 1'b1;
    #1 chk("ld_busy_cs", 64'(a_if.ld_busy), 64'd1);
    tick();
    a_idle();
    a_read("ld_dropped", 64'h20, 64'h5555555555555555);
    a_load(64'h20, 8'hAA);
    a_read("ld_stored", 64'h20, 64'hAA55555555555555);

    // Abort during WAIT: no drive, then a clean read still works.
    a_if.bus_addr = 64'h0;
    a_if.ram_cs   = 1'b1;
    a_if.ram_oe   = 1'b1;
    tick();
    a_if.ram_oe = 1'b0;
    #1 chk("abort_wait_ack", 64'(a_if.ram_ack), 64'd0);
    tick();
    a_idle();

    // Reset during WAIT with the request held: first post-reset cycle idle, memory kept.
    a_if.bus_addr = 64'h10;
    a_if.ram_cs   = 1'b1;
    a_if.ram_oe   = 1'b1;
    exp_q.push_back(64'hDEADBEEFCAFEF00D);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1 chk("post_reset_ack", 64'(a_if.ram_ack), 64'd0);
    a_wait_ack("rst_rd", 2);

    // Address change during WAIT on the 3-wait-state instance.
    b_if.bus_addr = 64'h0;
    b_wdat        = 64'hA0A1A2A3A4A5A6A7;
    b_drv         = 1'b1;
    b_if.ram_cs   = 1'b1;
    b_if.ram_we   = 1'b1;
    tick();
    b_if.bus_addr = 64'h8;
    b_wdat        = 64'hB0B1B2B3B4B5B6B7;
    tick();
    b_drv         = 1'b0;
    b_if.ram_we   = 1'b0;
    b_if.ram_oe   = 1'b1;
    b_if.bus_addr = 64'h0;
    exp_q.push_back(64'hB0B1B2B3B4B5B6B7);
    tick();
    b_if.bus_addr = 64'h8;
    c = 0;
    #1;
    while (!b_if.ram_ack && c < 20) begin
      @(posedge clk);
      #2;
      c++;
    end
    chk("addr_chg_lat", 64'(c), 64'd4);
    if (b_if.ram_ack) chk("addr_chg_data", b_dat, exp_q.pop_front());
    else              void'(exp_q.pop_front());
    b_if.ram_oe = 1'b0;
    #1 chk("addr_chg_release", 64'(b_if.ram_ack), 64'd0);
    tick();
    b_if.ram_cs = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
